imem_loader: RTL

- Instruction-memory responder for the Hack CPU: answers the CPU's program-counter fetches with 16-bit instructions from an internal RAM.
- Also implements the write end of that memory: a byte-stream loader (e.g. fed by a UART receiver) fills the RAM with a new program.
- Holds the CPU in reset while a load is in progress.
- Sits between the CPU's prog_counter/instruction pins and the host link.

---
 rtl/imem_loader.sv | 104 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Hack CPU instruction memory: registered fetch port plus a byte-stream loader
// that fills the RAM with a length-prefixed, big-endian program while holding the CPU in reset.
module imem_loader #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] prog_counter,
   output logic [15:0] instruction,
   output logic        cpu_reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        load_start,
   output logic [15:0] loaded_words,
   output logic        busy
);

   localparam int          DEPTH   = 2 ** ADDR_WIDTH;
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   typedef enum logic [2:0] {RUN, LEN_HI, LEN_LO, DATA_HI, DATA_LO} state_t;

   state_t      state;
   state_t      next_state;
   logic [15:0] mem [DEPTH];
   logic [15:0] addr;
   logic [15:0] len;
   logic [7:0]  hi_byte;
   logic        xfer;
   logic        wr_en;
   logic        pc_in_range;
   logic [16:0] addr_inc;

   assign busy        = (state != RUN);
   assign xfer        = byte_valid && byte_ready;
   assign addr_inc    = {1'b0, addr} + 17'd1;
   assign wr_en       = (state == DATA_LO) && xfer && ({1'b0, addr} < DEPTH_W);
   assign pc_in_range = ((prog_counter >> ADDR_WIDTH) == 16'd0);

   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (load_start) next_state = LEN_HI;
         LEN_HI:  if (xfer) next_state = LEN_LO;
         LEN_LO:  if (xfer) next_state = ({len[15:8], byte_in} == 16'd0) ? RUN : DATA_HI;
         DATA_HI: if (xfer) next_state = DATA_LO;
         DATA_LO: if (xfer) next_state = (addr_inc == {1'b0, len}) ? RUN : DATA_HI;
         default: next_state = RUN;
      endcase
   end

   // Control registers; cpu_reset and byte_ready follow the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         cpu_reset    <= 1'b1;
         byte_ready   <= 1'b0;
         loaded_words <= 16'd0;
         addr         <= 16'd0;
         len          <= 16'd0;
         hi_byte      <= 8'd0;
      end else begin
         state      <= next_state;
         cpu_reset  <= (next_state != RUN);
         byte_ready <= (next_state != RUN);
         case (state)
            RUN: begin
               if (load_start) begin
                  addr         <= 16'd0;
                  loaded_words <= 16'd0;
               end
            end
            LEN_HI:  if (xfer) len[15:8] <= byte_in;
            LEN_LO:  if (xfer) len[7:0]  <= byte_in;
            DATA_HI: if (xfer) hi_byte   <= byte_in;
            DATA_LO: begin
               if (xfer) begin
                  addr         <= addr_inc[15:0];
                  loaded_words <= (addr_inc > DEPTH_W) ? DEPTH_W[15:0] : addr_inc[15:0];
               end
            end
            default: ;
         endcase
      end
   end

   // Fetch port: one-cycle read; a same-cycle write is seen on the following read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         instruction <= 16'h0000;
      else if (!pc_in_range)
         instruction <= 16'h0000;
      else
         instruction <= mem[prog_counter[ADDR_WIDTH-1:0]];
   end

   // Words past the RAM depth are consumed from the stream but never written.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[addr[ADDR_WIDTH-1:0]] <= {hi_byte, byte_in};
   end

endmodule
